// File: rtl/tm_queue_depth.sv
// Per-queue packet depth table with enqueue/dequeue counting, a 2-cycle depth
// query pipeline and sticky overflow/underflow error reporting.
module tm_queue_depth #(
    parameter int QID_NBITS   = 6,
    parameter int DEPTH_NBITS = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enq_valid,
    input  logic [QID_NBITS-1:0]   enq_qid,
    input  logic                   deq_valid,
    input  logic [QID_NBITS-1:0]   deq_qid,
    input  logic                   queue_depth_req,
    input  logic [QID_NBITS-1:0]   queue_id,
    output logic                   queue_depth_ack,
    output logic [DEPTH_NBITS-1:0] queue_depth,
    output logic                   init_done,
    input  logic                   err_clr,
    output logic                   ovf_err,
    output logic                   udf_err,
    output logic [QID_NBITS-1:0]   err_qid
);

    localparam int                     NUM_QUEUES = 1 << QID_NBITS;
    localparam logic [DEPTH_NBITS-1:0] MAX_DEPTH  = '1;
    localparam logic [QID_NBITS-1:0]   LAST_QID   = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state;
    logic [QID_NBITS-1:0]   sweep_idx;
    logic [DEPTH_NBITS-1:0] depth_tbl [NUM_QUEUES];

    logic                   p1_valid;
    logic [QID_NBITS-1:0]   p1_qid;

    logic                   run;
    logic                   same_q;
    logic                   ovf_hit;
    logic                   udf_hit;
    logic                   enq_do;
    logic                   deq_do;
    logic [DEPTH_NBITS-1:0] enq_cur;
    logic [DEPTH_NBITS-1:0] deq_cur;
    logic [DEPTH_NBITS-1:0] byp_depth;

    // A same-qid enq/deq pair cancels out, so it can neither saturate nor underflow.
    always_comb begin
        run       = (state == RUN);
        enq_cur   = depth_tbl[enq_qid];
        deq_cur   = depth_tbl[deq_qid];
        same_q    = enq_valid && deq_valid && (enq_qid == deq_qid);
        ovf_hit   = run && enq_valid && !same_q && (enq_cur == MAX_DEPTH);
        udf_hit   = run && deq_valid && !same_q && (deq_cur == '0);
        enq_do    = run && enq_valid && !same_q && !ovf_hit;
        deq_do    = run && deq_valid && !same_q && !udf_hit;
        byp_depth = depth_tbl[p1_qid];
        if (enq_do && (enq_qid == p1_qid)) begin
            byp_depth = depth_tbl[p1_qid] + 1'b1;
        end else if (deq_do && (deq_qid == p1_qid)) begin
            byp_depth = depth_tbl[p1_qid] - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            depth_tbl[sweep_idx] <= '0;
        end else begin
            if (enq_do) depth_tbl[enq_qid] <= enq_cur + 1'b1;
            if (deq_do) depth_tbl[deq_qid] <= deq_cur - 1'b1;
        end
    end

    // The response forwards this cycle's table update so the returned depth
    // includes events presented one cycle after the request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= INIT;
            sweep_idx       <= '0;
            init_done       <= 1'b0;
            p1_valid        <= 1'b0;
            p1_qid          <= '0;
            queue_depth_ack <= 1'b0;
            queue_depth     <= '0;
            ovf_err         <= 1'b0;
            udf_err         <= 1'b0;
            err_qid         <= '0;
        end else begin
            if (state == INIT) begin
                sweep_idx <= sweep_idx + 1'b1;
                if (sweep_idx == LAST_QID) state <= RUN;
            end
            init_done       <= run;
            p1_valid        <= queue_depth_req;
            p1_qid          <= queue_id;
            queue_depth_ack <= p1_valid;
            if (p1_valid) queue_depth <= run ? byp_depth : '0;

            if (ovf_hit || udf_hit) begin
                ovf_err <= ovf_hit || (ovf_err && !err_clr);
                udf_err <= udf_hit || (udf_err && !err_clr);
                if (err_clr || (!ovf_err && !udf_err)) begin
                    err_qid <= ovf_hit ? enq_qid : deq_qid;
                end
            end else if (err_clr) begin
                ovf_err <= 1'b0;
                udf_err <= 1'b0;
                err_qid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tm_queue_depth.sv
// Self-checking bench for tm_queue_depth: a per-queue depth model driven by
// directed scenarios and randomized traffic, compared every cycle.
module tb_tm_queue_depth;

    localparam int QID_NBITS   = 6;
    localparam int DEPTH_NBITS = 6;
    localparam int NQ          = 1 << QID_NBITS;
    localparam int MAXD        = (1 << DEPTH_NBITS) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   enq_valid;
    logic [QID_NBITS-1:0]   enq_qid;
    logic                   deq_valid;
    logic [QID_NBITS-1:0]   deq_qid;
    logic                   queue_depth_req;
    logic [QID_NBITS-1:0]   queue_id;
    logic                   queue_depth_ack;
    logic [DEPTH_NBITS-1:0] queue_depth;
    logic                   init_done;
    logic                   err_clr;
    logic                   ovf_err;
    logic                   udf_err;
    logic [QID_NBITS-1:0]   err_qid;

    int vectors    = 0;
    int miscompares = 0;
    bit checking   = 1'b0;

    int mdl [NQ];
    int nxt [NQ];
    int sweep_edges;
    bit prev_req;
    int prev_qid;
    bit ovf_ev;
    bit udf_ev;
    bit capture;
    bit run_now;
    int exp_ack, exp_depth, exp_init, exp_ovf, exp_udf, exp_errq;

    tm_queue_depth #(.QID_NBITS(QID_NBITS), .DEPTH_NBITS(DEPTH_NBITS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enq_valid       (enq_valid),
        .enq_qid         (enq_qid),
        .deq_valid       (deq_valid),
        .deq_qid         (deq_qid),
        .queue_depth_req (queue_depth_req),
        .queue_id        (queue_id),
        .queue_depth_ack (queue_depth_ack),
        .queue_depth     (queue_depth),
        .init_done       (init_done),
        .err_clr         (err_clr),
        .ovf_err         (ovf_err),
        .udf_err         (udf_err),
        .err_qid         (err_qid)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then return at the negedge after they were sampled.
    task automatic apply_stimulus(input bit ev, input int eq, input bit dv, input int dq,
                                  input bit rq, input int qq, input bit clr);
        enq_valid       = ev;
        enq_qid         = QID_NBITS'(eq);
        deq_valid       = dv;
        deq_qid         = QID_NBITS'(dq);
        queue_depth_req = rq;
        queue_id        = QID_NBITS'(qq);
        err_clr         = clr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_query(input string name, input int qid, input int expected);
        apply_stimulus(0, 0, 0, 0, 1, qid, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output({name, "_ack"}, queue_depth_ack, 1);
        check_output(name, queue_depth, expected);
    endtask

    task automatic sweep_check(input string name, input bit probe);
        for (int i = 0; i < NQ; i++) begin
            apply_stimulus(0, 0, 0, 0, probe && (i == 10), 12, 0);
            if (probe && i == 11) begin
                check_output("init_query_ack", queue_depth_ack, 1);
                check_output("init_query_depth", queue_depth, 0);
            end
        end
        check_output({name, "_64"}, init_done, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output({name, "_65"}, init_done, 1);
    endtask

    // Reference model: a plain array of depths, events applied from the
    // rules, responses taken from the depths after the cycle following the request.
    always @(posedge clk) begin
        if (!rst_n) begin
            sweep_edges = 0;
            foreach (mdl[i]) mdl[i] = 0;
            prev_req  = 0;
            prev_qid  = 0;
            exp_ack   = 0;
            exp_depth = 0;
            exp_init  = 0;
            exp_ovf   = 0;
            exp_udf   = 0;
            exp_errq  = 0;
        end else begin
            run_now = (sweep_edges >= NQ);
            nxt = mdl;
            ovf_ev = 0;
            udf_ev = 0;
            if (run_now && !(enq_valid && deq_valid && enq_qid == deq_qid)) begin
                if (enq_valid) begin
                    if (mdl[enq_qid] == MAXD) ovf_ev = 1;
                    else nxt[enq_qid] = mdl[enq_qid] + 1;
                end
                if (deq_valid) begin
                    if (mdl[deq_qid] == 0) udf_ev = 1;
                    else nxt[deq_qid] = mdl[deq_qid] - 1;
                end
            end
            exp_ack = prev_req ? 1 : 0;
            if (prev_req) exp_depth = run_now ? nxt[prev_qid] : 0;
            if (ovf_ev || udf_ev) begin
                capture = err_clr || (exp_ovf == 0 && exp_udf == 0);
                exp_ovf = (ovf_ev || (exp_ovf != 0 && !err_clr)) ? 1 : 0;
                exp_udf = (udf_ev || (exp_udf != 0 && !err_clr)) ? 1 : 0;
                if (capture) exp_errq = ovf_ev ? int'(enq_qid) : int'(deq_qid);
            end else if (err_clr) begin
                exp_ovf  = 0;
                exp_udf  = 0;
                exp_errq = 0;
            end
            mdl = nxt;
            prev_req = queue_depth_req;
            prev_qid = queue_id;
            exp_init = (sweep_edges + 1 > NQ) ? 1 : 0;
            if (sweep_edges < 1000) sweep_edges++;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check_output("ack", queue_depth_ack, exp_ack);
            check_output("depth", queue_depth, exp_depth);
            check_output("init_done", init_done, exp_init);
            check_output("ovf_err", ovf_err, exp_ovf);
            check_output("udf_err", udf_err, exp_udf);
            check_output("err_qid", err_qid, exp_errq);
        end
    end

    initial begin
        rst_n = 0;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        idle(2);
        checking = 1;
        check_output("reset_ack", queue_depth_ack, 0);
        check_output("reset_init_done", init_done, 0);
        check_output("reset_depth", queue_depth, 0);

        rst_n = 1;
        sweep_check("init_done_rise", 1);

        for (int q = 0; q < NQ; q++) apply_stimulus(0, 0, 0, 0, 1, q, 0);
        idle(2);
        do_query("all_zero_q63", 63, 0);

        for (int i = 0; i < 3; i++) apply_stimulus(1, 5, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 1, 5, 0, 0, 0);
        do_query("q5_depth", 5, 2);

        apply_stimulus(1, 7, 0, 0, 1, 7, 0);
        apply_stimulus(1, 7, 0, 0, 0, 0, 0);
        check_output("q7_window_ack", queue_depth_ack, 1);
        check_output("q7_window", queue_depth, 2);
        apply_stimulus(1, 7, 0, 0, 0, 0, 0);
        check_output("q7_hold", queue_depth, 2);
        do_query("q7_after", 7, 3);

        for (int i = 0; i < MAXD; i++) apply_stimulus(1, 3, 0, 0, 0, 0, 0);
        check_output("q3_no_ovf_yet", ovf_err, 0);
        apply_stimulus(1, 3, 0, 0, 0, 0, 0);
        check_output("q3_ovf", ovf_err, 1);
        check_output("q3_err_qid", err_qid, 3);
        do_query("q3_saturated", 3, MAXD);
        apply_stimulus(0, 0, 1, 9, 0, 0, 0);
        check_output("q9_udf", udf_err, 1);
        check_output("q9_err_qid_kept", err_qid, 3);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_output("clr_ovf", ovf_err, 0);
        check_output("clr_udf", udf_err, 0);
        check_output("clr_err_qid", err_qid, 0);

        apply_stimulus(1, 4, 1, 4, 0, 0, 0);
        check_output("q4_same_no_udf", udf_err, 0);
        do_query("q4_same", 4, 0);
        apply_stimulus(1, 2, 0, 0, 0, 0, 0);
        apply_stimulus(1, 1, 1, 2, 0, 0, 0);
        do_query("q1_split", 1, 1);
        do_query("q2_split", 2, 0);

        for (int i = 0; i < 1600; i++) begin
            int enq_pct = (i < 800) ? 75 : 30;
            int deq_pct = (i < 800) ? 30 : 70;
            apply_stimulus($urandom_range(0, 99) < enq_pct, $urandom_range(0, 3),
                           $urandom_range(0, 99) < deq_pct, $urandom_range(0, 3),
                           $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                           $urandom_range(0, 99) < 3);
        end
        idle(3);

        for (int i = 0; i < 10; i++) begin
            if (i == 5) rst_n = 0;
            apply_stimulus(0, 0, 0, 0, 1, i, 0);
            if (i >= 5) begin
                check_output("rst_no_ack", queue_depth_ack, 0);
                check_output("rst_init_done", init_done, 0);
            end
        end
        idle(2);
        check_output("rst_drained_ack", queue_depth_ack, 0);
        rst_n = 1;
        sweep_check("resweep", 0);
        do_query("resweep_q3", 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tm_queue_depth.md
TM_QUEUE_DEPTH -- requirements
Module: tm_queue_depth

Interface
REQ-001 Parameter QID_NBITS, default 6, width of first-level queue id; table holds 2^QID_NBITS entries.
REQ-002 Parameter DEPTH_NBITS, default 6, width of each per-queue depth counter; maximum depth is 2^DEPTH_NBITS-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enq_valid  input  1  one packet enqueued to queue enq_qid this cycle.
REQ-006 enq_qid  input  QID_NBITS  queue id of the enqueue event.
REQ-007 deq_valid  input  1  one packet dequeued from queue deq_qid this cycle.
REQ-008 deq_qid  input  QID_NBITS  queue id of the dequeue event.
REQ-009 queue_depth_req  input  1  single-cycle depth query strobe; one query per cycle is allowed.
REQ-010 queue_id  input  QID_NBITS  queue id being queried; valid with queue_depth_req.
REQ-011 queue_depth_ack  output  1  single-cycle response strobe.
REQ-012 queue_depth  output  DEPTH_NBITS  depth of the queried queue; valid with queue_depth_ack.
REQ-013 init_done  output  1  high once the table clear sweep has completed.
REQ-014 err_clr  input  1  clears the sticky error outputs.
REQ-015 ovf_err  output  1  sticky; an enqueue hit a saturated counter.
REQ-016 udf_err  output  1  sticky; a dequeue hit a zero counter.
REQ-017 err_qid  output  QID_NBITS  queue id of the first error since the last clear.

Function
REQ-018 Two-state FSM SHALL be used: INIT and RUN; reset forces INIT with the sweep index at 0.
REQ-019 In INIT the block SHALL write 0 to table[index] and increment the index by one each cycle; after the entry 2^QID_NBITS-1 is written it SHALL go to RUN and set init_done=1 on the next cycle.
REQ-020 In INIT, enq_valid and deq_valid SHALL be ignored.
REQ-021 In RUN, enq_valid SHALL increment table[enq_qid] by 1 at the end of the cycle; deq_valid SHALL decrement table[deq_qid] by 1.
REQ-022 Simultaneous enq and deq to the same qid SHALL leave that entry unchanged and flag no error.
REQ-023 Simultaneous enq and deq to different qids SHALL both take effect in the same cycle.
REQ-024 An enqueue to an entry at 2^DEPTH_NBITS-1 SHALL leave the entry unchanged and set ovf_err.
REQ-025 A dequeue from an entry at 0 SHALL leave the entry unchanged and set udf_err.
REQ-026 err_qid SHALL capture the qid of the first error while both sticky flags are clear; if overflow and underflow occur in the same cycle, the enqueue qid SHALL be captured.
REQ-027 err_clr SHALL clear ovf_err, udf_err and err_qid to 0 next cycle; an error in the same cycle SHALL take priority over the clear.
REQ-028 The query pipeline SHALL be exactly 2 cycles: a request sampled at cycle T SHALL produce queue_depth_ack=1 at cycle T+2, with queue_depth driven in the same cycle.
REQ-029 The returned depth SHALL include all enq/deq events presented in cycles up to and including T+1; it SHALL exclude events from later cycles.
REQ-030 Back-to-back queries SHALL be fully pipelined, with one ack per request, in order and without loss.
REQ-031 A query whose response is generated while the FSM is in INIT SHALL return depth 0 and still be acked at T+2.
REQ-032 queue_depth SHALL hold its last value when queue_depth_ack=0.

Reset
REQ-033 When rst_n=0 is sampled, the following SHALL be 0 on the next cycle: queue_depth_ack, queue_depth, init_done, ovf_err, udf_err, err_qid, and all pipeline valid bits; the FSM SHALL enter INIT at index 0.
REQ-034 Reset asserted mid-operation SHALL drop in-flight queries, producing no ack, and SHALL restart the full clear sweep.
REQ-035 Table contents SHALL need no reset; they are cleared by the INIT sweep.

Verification
REQ-036 Release reset, count cycles -> init_done rises exactly 65 cycles later (QID_NBITS=6); a query of every qid then returns 0.
REQ-037 3 enqueues to qid 5, 1 dequeue to qid 5, then query qid 5 -> ack 2 cycles after the request, queue_depth=2.
REQ-038 Enqueue to qid 7 in the same cycle as the query of qid 7, and again one cycle later -> response reflects both events; an event two cycles after the request is excluded.
REQ-039 Fill qid 3 to 63, then enqueue once more -> depth stays 63, ovf_err=1, err_qid=3; dequeue from empty qid 9 -> udf_err=1, err_qid still 3; err_clr -> all flags 0.
REQ-040 Same-cycle enq/deq on qid 4 at depth 0 -> depth 0, no udf_err; same-cycle enq qid 1 and deq qid 2 at depth 1 -> qid1=1, qid2=0.
REQ-041 Query every cycle for 10 cycles, assert rst_n=0 mid-stream -> no acks after reset, init_done=0, sweep restarts.
